// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external ripple-carry adder among NREQ requesters.
// Registers the winner's operands, waits SETTLE cycles for the ripple, then captures the sum.
module adder_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  op_a,
    input  logic [NREQ*WIDTH-1:0]  op_b,
    input  logic [NREQ-1:0]        cin,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       result,
    output logic                   cout,
    output logic                   busy,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic              add_cin_q, add_cin_d;

    logic [IW-1:0]     winner;
    logic              anyReq;

    // Search from last+1 upward; walking k downward lets the nearest requester overwrite the rest.
    always_comb begin
        int idx;
        idx    = 0;
        winner = last_q;
        anyReq = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[IW'(idx)]) begin
                winner = IW'(idx);
                anyReq = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        result_d  = result_q;
        cout_d    = cout_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;

        unique case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    add_a_d   = op_a[winner*WIDTH +: WIDTH];
                    add_b_d   = op_b[winner*WIDTH +: WIDTH];
                    add_cin_d = cin[winner];
                    gnt_d     = NREQ'(1) << winner;
                    last_d    = winner;
                    cnt_d     = CW'(SETTLE - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    result_d = add_sum;
                    cout_d   = add_cout;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= IW'(NREQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign busy    = (state_q != ST_IDLE);
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: a behavioural adder drives add_sum/add_cout,
// expectations come from a round-robin model and plain arithmetic on the operands.
module tb_adder_share_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 16;
    localparam int SETTLE = 4;
    localparam int PERIOD = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] opA = '0;
    logic [NREQ*WIDTH-1:0] opB = '0;
    logic [NREQ-1:0]       cin = '0;
    logic [NREQ-1:0]       gnt, done;
    logic [WIDTH-1:0]      result, addA, addB, addSum;
    logic                  cout, busy, addCin, addCout;

    int errors = 0;
    int checks = 0;
    int modelLast = NREQ - 1;
    int cycleCount = 0;
    int lastGrantCycle = -1;
    int oneHotViolations = 0;

    typedef struct {
        logic [NREQ-1:0]  reqMask;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        int               expWin;
        logic [WIDTH-1:0] expRes;
        logic             expCout;
    } vec_t;

    vec_t vecs[8];

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(opA), .op_b(opB), .cin(cin),
        .gnt(gnt), .done(done), .result(result), .cout(cout), .busy(busy),
        .add_a(addA), .add_b(addB), .add_cin(addCin),
        .add_sum(addSum), .add_cout(addCout)
    );

    always #(PERIOD/2) clk = ~clk;

    // Shared adder stand-in with a short ripple delay well inside one clock.
    assign #2 {addCout, addSum} = {1'b0, addA} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};

    always @(posedge clk) cycleCount++;

    always @(negedge clk) begin
        if (!rst && ($countones(gnt) > 1 || $countones(done) > 1)) oneHotViolations++;
    end

    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int pickWinner(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (modelLast + k) % NREQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH:0] refSum(input int w);
        return {1'b0, opA[w*WIDTH +: WIDTH]} + {1'b0, opB[w*WIDTH +: WIDTH]} + (WIDTH+1)'(cin[w]);
    endfunction

    task automatic applyStimulus(input int w, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        for (int i = 0; i < NREQ; i++) begin
            opA[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            opB[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        cin = NREQ'($urandom);
        opA[w*WIDTH +: WIDTH] = a;
        opB[w*WIDTH +: WIDTH] = b;
        cin[w] = c;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = '0;
        stepCycle();
        stepCycle();
        checkOutput("reset.gnt", 32'(gnt), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.cout", 32'(cout), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.addA", 32'(addA), 32'd0);
        checkOutput("reset.addB", 32'(addB), 32'd0);
        checkOutput("reset.addCin", 32'(addCin), 32'd0);
        rst = 1'b0;
        modelLast = NREQ - 1;
        lastGrantCycle = -1;
    endtask

    // One full transaction starting in IDLE; operands are scrambled right after the grant.
    task automatic runOp(input string tag, input logic [NREQ-1:0] reqMask, input logic [NREQ-1:0] nextReq,
                         input int expWin, input logic [WIDTH-1:0] expRes, input logic expCout,
                         input bit checkSpacing);
        logic [WIDTH-1:0] snapA, snapB;
        logic             snapC;
        logic [NREQ-1:0]  expOneHot;
        int               n;
        expOneHot = NREQ'(1) << expWin;
        snapA = opA[expWin*WIDTH +: WIDTH];
        snapB = opB[expWin*WIDTH +: WIDTH];
        snapC = cin[expWin];
        req = reqMask;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (gnt == '0 && n < 4 * SETTLE);
        checkOutput({tag, ".grantLatency"}, 32'(n), 32'd1);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(expOneHot));
        checkOutput({tag, ".busyGrant"}, 32'(busy), 32'd1);
        checkOutput({tag, ".addA"}, 32'(addA), 32'(snapA));
        checkOutput({tag, ".addB"}, 32'(addB), 32'(snapB));
        checkOutput({tag, ".addCin"}, 32'(addCin), 32'(snapC));
        if (checkSpacing) checkOutput({tag, ".grantSpacing"}, 32'(cycleCount - lastGrantCycle), 32'(SETTLE + 2));
        lastGrantCycle = cycleCount;
        modelLast = expWin;
        applyStimulus(expWin, 16'h7000, WIDTH'($urandom), 1'($urandom));
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (done == '0 && n < 4 * SETTLE);
        checkOutput({tag, ".doneLatency"}, 32'(n), 32'(SETTLE));
        checkOutput({tag, ".done"}, 32'(done), 32'(expOneHot));
        checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
        checkOutput({tag, ".gntCleared"}, 32'(gnt), 32'd0);
        req = nextReq;
        stepCycle();
        checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, ".busyIdle"}, 32'(busy), 32'd0);
        checkOutput({tag, ".resultHeld"}, 32'(result), 32'(expRes));
    endtask

    initial begin
        logic [WIDTH:0]  ref17;
        logic [NREQ-1:0] mask, pend, nextMask;
        int              w;

        vecs[0] = '{4'b0001, 16'h1234, 16'h0FF0, 1'b0, 0, 16'h2224, 1'b0};
        vecs[1] = '{4'b0100, 16'hFFFF, 16'h0001, 1'b1, 2, 16'h0001, 1'b1};
        vecs[2] = '{4'b0010, 16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1};
        vecs[3] = '{4'b1010, 16'h00FF, 16'h0F01, 1'b1, 3, 16'h1001, 1'b0};
        vecs[4] = '{4'b1010, 16'h7FFF, 16'h7FFF, 1'b1, 1, 16'hFFFF, 1'b0};
        vecs[5] = '{4'b1111, 16'h0000, 16'h0000, 1'b0, 2, 16'h0000, 1'b0};
        vecs[6] = '{4'b1001, 16'hABCD, 16'h1111, 1'b0, 3, 16'hBCDE, 1'b0};
        vecs[7] = '{4'b0001, 16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1};

        $display("[TB] reset and directed vectors");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].expWin, vecs[i].a, vecs[i].b, vecs[i].c);
            runOp($sformatf("vec%0d", i), vecs[i].reqMask, '0, vecs[i].expWin,
                  vecs[i].expRes, vecs[i].expCout, 1'b0);
        end

        $display("[TB] full contention from reset release");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i % NREQ, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            ref17 = refSum(i % NREQ);
            runOp($sformatf("cont%0d", i), 4'b1111, 4'b1111, i % NREQ,
                  ref17[WIDTH-1:0], ref17[WIDTH], i != 0);
        end
        req = '0;

        $display("[TB] operand hold");
        applyStimulus(0, 16'h0001, 16'h0001, 1'b0);
        runOp("hold", 4'b0001, '0, pickWinner(4'b0001), 16'h0002, 1'b0, 1'b0);

        $display("[TB] reset during WAIT");
        applyStimulus(2, 16'h1111, 16'h2222, 1'b0);
        req = 4'b0100;
        stepCycle();
        checkOutput("midRst.gnt", 32'(gnt), 32'h4);
        req = '0;
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        modelLast = NREQ - 1;
        checkOutput("midRst.gntAfter", 32'(gnt), 32'd0);
        checkOutput("midRst.busyAfter", 32'(busy), 32'd0);
        checkOutput("midRst.resultAfter", 32'(result), 32'd0);
        checkOutput("midRst.addAAfter", 32'(addA), 32'd0);
        for (int i = 0; i < SETTLE + 2; i++) begin
            checkOutput("midRst.noDone", 32'(done), 32'd0);
            stepCycle();
        end
        applyStimulus(0, 16'h0F0F, 16'h00F1, 1'b1);
        runOp("afterRst0", 4'b1001, 4'b1000, pickWinner(4'b1001), 16'h1001, 1'b0, 1'b0);
        applyStimulus(3, 16'hC000, 16'h4000, 1'b0);
        runOp("afterRst3", 4'b1000, '0, pickWinner(4'b1000), 16'h0000, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        pend = '0;
        for (int i = 0; i < 40; i++) begin
            mask = pend | NREQ'($urandom);
            if (mask == '0) mask = NREQ'(1) << $urandom_range(0, NREQ - 1);
            w = pickWinner(mask);
            applyStimulus(w, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            ref17 = refSum(w);
            nextMask = mask & ~(NREQ'(1) << w) & NREQ'($urandom);
            runOp($sformatf("rand%0d", i), mask, nextMask, w, ref17[WIDTH-1:0], ref17[WIDTH], 1'b0);
            pend = nextMask;
        end
        req = '0;
        stepCycle();

        checkOutput("oneHotViolations", 32'(oneHotViolations), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
